// File: rtl/pcdm_sched_pkg.sv
// Shared types and constants for the payload de-mapper read scheduler.
// Optional feature switch used by pcdm_sched: PCDM_SCHED_STALL_CNT_EN.
package pcdm_sched_pkg;

  // Scheduler FSM encoding; the values are visible on the debug state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // 16QAM carries four LLRs per constellation symbol.
  localparam int BITS_PER_SYM_DEF = 4;

  // Data subcarriers per OFDM symbol.
  localparam int SYM_PER_OFDM_DEF = 48;

  // Width of the backpressure stall counter.
  localparam int STALL_W = 16;

endpackage

// File: rtl/pcdm_sat_cnt.sv
// Generic up-counter that sticks at all-ones and has a synchronous clear.
// Used for the backpressure stall counter when PCDM_SCHED_STALL_CNT_EN is set.
module pcdm_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; the count never wraps past all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pcdm_sched.sv
// Read scheduler for the de-mapper input FIFOs: issues single-symbol reads,
// latches each symbol, then serialises it into BITS_PER_SYM LLR beats under
// downstream backpressure and flags the last LLR of each OFDM symbol.
// Optional: PCDM_SCHED_STALL_CNT_EN enables the 16-bit saturating stall counter;
// without it stall_cnt is tied to zero.
// Handshake: an LLR beat transfers on a cycle where llr_vld && do_rdy; once
// llr_vld is high it stays high with bit_idx stable until that transfer.
module pcdm_sched
  import pcdm_sched_pkg::*;
#(
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF,
  parameter int SYM_PER_OFDM = SYM_PER_OFDM_DEF,
  localparam int BW = $clog2(BITS_PER_SYM),
  localparam int SW = $clog2(SYM_PER_OFDM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fifo_empty,
  input  logic               fifo_valid,
  output logic               fifo_rd_en,
  output logic               sym_load,
  output logic [BW-1:0]      bit_idx,
  output logic               llr_vld,
  input  logic               do_rdy,
  output logic               llr_last,
  output logic [SW-1:0]      sym_cnt,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt,
  output logic [1:0]         fsm_state
);

  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_SYM - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_PER_OFDM - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] bit_idx_q;
  logic [SW-1:0] sym_cnt_q;
  logic          final_beat;

  // The last LLR of the current symbol is being accepted this cycle.
  assign final_beat = (state_q == EMIT) && (bit_idx_q == BIT_LAST) && do_rdy;

  // Reads are only issued from IDLE or back-to-back on the final beat; never on flush.
  assign fifo_rd_en = !flush && !fifo_empty && ((state_q == IDLE) || final_beat);

  // A late read return after a flush lands in IDLE and is dropped here.
  assign sym_load  = !flush && (state_q == LOAD) && fifo_valid;
  assign llr_vld   = (state_q == EMIT);
  assign llr_last  = (state_q == EMIT) && (bit_idx_q == BIT_LAST) && (sym_cnt_q == SYM_LAST);
  assign busy      = (state_q != IDLE);
  assign bit_idx   = bit_idx_q;
  assign sym_cnt   = sym_cnt_q;
  assign fsm_state = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_rd_en) state_d = LOAD;
      LOAD:    if (fifo_valid) state_d = EMIT;
      EMIT:    if (final_beat) state_d = fifo_rd_en ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // LLR select: restarts on each symbol load, advances on every accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx_q <= '0;
    end else if (flush) begin
      bit_idx_q <= '0;
    end else if ((state_q == LOAD) && fifo_valid) begin
      bit_idx_q <= '0;
    end else if ((state_q == EMIT) && do_rdy) begin
      bit_idx_q <= bit_idx_q + BW'(1);
    end
  end

  // Subcarrier index within the OFDM symbol, wrapping after the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_cnt_q <= '0;
    end else if (flush) begin
      sym_cnt_q <= '0;
    end else if (final_beat) begin
      sym_cnt_q <= (sym_cnt_q == SYM_LAST) ? '0 : sym_cnt_q + SW'(1);
    end
  end

`ifdef PCDM_SCHED_STALL_CNT_EN
  pcdm_sat_cnt #(
    .W (STALL_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc ((state_q == EMIT) && !do_rdy),
    .cnt (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pcdm_sched.sv
// Directed bench for pcdm_sched: single symbol, 48 back-to-back symbols,
// backpressure stall, FIFO running dry on the final beat, flush during an
// in-flight read and asynchronous reset mid-symbol.
module tb_pcdm_sched;
  import pcdm_sched_pkg::*;

  localparam int BPS = 4;
  localparam int SPO = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_valid = 1'b0;
  logic        do_rdy = 1'b0;
  logic        fifo_rd_en;
  logic        sym_load;
  logic [1:0]  bit_idx;
  logic        llr_vld;
  logic        llr_last;
  logic [5:0]  sym_cnt;
  logic        busy;
  logic [15:0] stall_cnt;
  logic [1:0]  fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PCDM_SCHED_STALL_CNT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  pcdm_sched dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_rd_en (fifo_rd_en),
    .sym_load   (sym_load),
    .bit_idx    (bit_idx),
    .llr_vld    (llr_vld),
    .do_rdy     (do_rdy),
    .llr_last   (llr_last),
    .sym_cnt    (sym_cnt),
    .busy       (busy),
    .stall_cnt  (stall_cnt),
    .fsm_state  (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rd, input logic ld, input int bi,
                         input logic vld, input logic last, input logic bsy);
    chk({tag, ".rd_en"},    32'(fifo_rd_en), 32'(rd));
    chk({tag, ".sym_load"}, 32'(sym_load),   32'(ld));
    chk({tag, ".bit_idx"},  32'(bit_idx),    32'(bi));
    chk({tag, ".llr_vld"},  32'(llr_vld),    32'(vld));
    chk({tag, ".llr_last"}, 32'(llr_last),   32'(last));
    chk({tag, ".busy"},     32'(busy),       32'(bsy));
  endtask

  // One clock: inputs change 1ns after the edge, outputs are checked 2ns after it.
  task automatic cyc(input logic e, input logic v, input logic r, input logic f);
    @(posedge clk);
    #1;
    fifo_empty = e;
    fifo_valid = v;
    do_rdy     = r;
    flush      = f;
    #1;
  endtask

  // Four accepted beats of one symbol with an empty FIFO behind it.
  task automatic run_beats(input string tag, input int sym);
    for (int i = 0; i < BPS; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk_all($sformatf("%s.b%0d", tag, i), 1'b0, 1'b0, i, 1'b1, 1'b0, 1'b1);
      chk($sformatf("%s.b%0d.sym_cnt", tag, i), 32'(sym_cnt), 32'(sym));
    end
  endtask

  initial begin
    int   items;
    int   beats;
    int   final_cyc;
    logic prev_rd;

    // ---- reset values ----
    #22;
    chk_all("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset.sym_cnt", 32'(sym_cnt), 32'd0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---- single symbol, do_rdy high ----
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("one.t0", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("one.t1", 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    chk("one.t1.state", 32'(fsm_state), 32'(LOAD));
    run_beats("one", 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("one.end", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("one.end.sym_cnt", 32'(sym_cnt), 32'd1);

    // ---- flush in IDLE clears sym_cnt ----
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_idle.sym_cnt", 32'(sym_cnt), 32'd0);

    // ---- 48 symbols back-to-back with a 1-cycle-latency FIFO model ----
    items = SPO;
    prev_rd = 1'b0;
    beats = 0;
    final_cyc = -1;
    for (int c = 0; c < 300 && beats < SPO * BPS; c++) begin
      cyc(items == 0, prev_rd, 1'b1, 1'b0);
      prev_rd = fifo_rd_en;
      if (fifo_rd_en) items--;
      if (llr_vld && do_rdy) begin
        chk("b2b.bit_idx", 32'(bit_idx), 32'(beats % BPS));
        chk("b2b.sym_cnt", 32'(sym_cnt), 32'(beats / BPS));
        chk("b2b.llr_last", 32'(llr_last), 32'(beats == SPO * BPS - 1));
        beats++;
        if (beats == SPO * BPS) final_cyc = c;
      end
    end
    chk("b2b.beats", 32'(beats), 32'd192);
    chk("b2b.final_cycle", 32'(final_cyc), 32'd240);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("b2b.end", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("b2b.end.sym_cnt", 32'(sym_cnt), 32'd0);

    // ---- backpressure at bit_idx=2 for three cycles ----
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("stall.t0", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("stall.t1", 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("stall.b0", 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("stall.b1", 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk_all($sformatf("stall.hold%0d", i), 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("stall.b2", 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    chk("stall.stall_cnt", 32'(stall_cnt), 32'(EXP_STALL));
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("stall.b3", 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("stall.end", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("stall.end.sym_cnt", 32'(sym_cnt), 32'd1);
    chk("stall.end.stall_cnt", 32'(stall_cnt), 32'(EXP_STALL));

    // ---- FIFO empties on the final beat, then restarts ----
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("dry.t0", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk_all("dry.t1", 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < BPS - 1; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk_all($sformatf("dry.b%0d", i), 1'b0, 1'b0, i, 1'b1, 1'b0, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("dry.b3", 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("dry.idle0", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("dry.idle0.sym_cnt", 32'(sym_cnt), 32'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("dry.idle1", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("dry.restart", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("dry.load", 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_beats("dry2", 2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("dry2.end.sym_cnt", 32'(sym_cnt), 32'd3);

    // ---- flush while the read is in flight ----
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("fl.t0", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk_all("fl.load", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("fl.late", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("fl.late.sym_cnt", 32'(sym_cnt), 32'd0);
    chk("fl.late.stall_cnt", 32'(stall_cnt), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("fl.after", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // ---- asynchronous reset mid-EMIT ----
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    run_beats("pre", 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("ar.t0", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("ar.t0.sym_cnt", 32'(sym_cnt), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("ar.b0", 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("ar.b1", 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    chk("ar.b1.stall_cnt", 32'(stall_cnt), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk_all("ar.in_reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("ar.in_reset.sym_cnt", 32'(sym_cnt), 32'd0);
    chk("ar.in_reset.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("ar.restart", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("ar.load", 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_beats("ar2", 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("ar.end", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("ar.end.sym_cnt", 32'(sym_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
